// File: rtl/maptable_pkg.sv
// Shared constants and entry type for the speculative rename map table.
// The reset identity mapping lives here so the table and its users agree on it.
package maptable_pkg;

    localparam int CDBWIDTH  = 6;
    localparam int NUM_AREGS = 32;
    localparam int AREG_W    = 5;

    localparam logic [AREG_W-1:0] ZERO_REG = 5'd31;

    typedef struct packed {
        logic [CDBWIDTH-1:0] preg;
        logic                ready;
    } entry_t;

    // Architectural register i maps to physical register i and is ready.
    function automatic entry_t reset_entry(input int i);
        entry_t e;
        e.preg  = CDBWIDTH'(i);
        e.ready = 1'b1;
        return e;
    endfunction

endpackage

// File: rtl/maptable_read_port.sv
// One rename lookup port: table read with the slot-A destination bypass
// and same-cycle CDB wakeup folded into the ready bit.
module maptable_read_port
    import maptable_pkg::*;
(
    input  logic [AREG_W-1:0]             i_idx,
    input  entry_t [NUM_AREGS-1:0]        i_table,
    input  logic                          i_byp_en,
    input  logic [AREG_W-1:0]             i_byp_idx,
    input  logic [CDBWIDTH-1:0]           i_byp_preg,
    input  logic                          i_cdbA_en,
    input  logic [CDBWIDTH-1:0]           i_cdbA_tag,
    input  logic                          i_cdbB_en,
    input  logic [CDBWIDTH-1:0]           i_cdbB_tag,
    output logic [CDBWIDTH-1:0]           o_preg,
    output logic                          o_ready
);

    entry_t w_entry;
    logic   w_byp_hit;

    assign w_entry   = i_table[i_idx];
    assign w_byp_hit = i_byp_en && (i_byp_idx == i_idx) && (i_idx != ZERO_REG);

    // NOTE: both outputs get a value on every path, so no latch is inferred.
    always_comb begin
        if (w_byp_hit) begin
            o_preg  = i_byp_preg;
            o_ready = 1'b0;
        end else begin
            o_preg  = w_entry.preg;
            o_ready = w_entry.ready
                    | (i_cdbA_en && (i_cdbA_tag == w_entry.preg))
                    | (i_cdbB_en && (i_cdbB_tag == w_entry.preg));
        end
    end

endmodule

// File: rtl/maptable.sv
// R10K-style speculative map table: two-wide rename, CDB ready wakeup,
// and wholesale restore from the architectural table on ROB recovery.
module maptable
    import maptable_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                rob_recover,
    input  logic [CDBWIDTH-1:0] archtable_copy_0,
    input  logic [CDBWIDTH-1:0] archtable_copy_1,
    input  logic [CDBWIDTH-1:0] archtable_copy_2,
    input  logic [CDBWIDTH-1:0] archtable_copy_3,
    input  logic [CDBWIDTH-1:0] archtable_copy_4,
    input  logic [CDBWIDTH-1:0] archtable_copy_5,
    input  logic [CDBWIDTH-1:0] archtable_copy_6,
    input  logic [CDBWIDTH-1:0] archtable_copy_7,
    input  logic [CDBWIDTH-1:0] archtable_copy_8,
    input  logic [CDBWIDTH-1:0] archtable_copy_9,
    input  logic [CDBWIDTH-1:0] archtable_copy_10,
    input  logic [CDBWIDTH-1:0] archtable_copy_11,
    input  logic [CDBWIDTH-1:0] archtable_copy_12,
    input  logic [CDBWIDTH-1:0] archtable_copy_13,
    input  logic [CDBWIDTH-1:0] archtable_copy_14,
    input  logic [CDBWIDTH-1:0] archtable_copy_15,
    input  logic [CDBWIDTH-1:0] archtable_copy_16,
    input  logic [CDBWIDTH-1:0] archtable_copy_17,
    input  logic [CDBWIDTH-1:0] archtable_copy_18,
    input  logic [CDBWIDTH-1:0] archtable_copy_19,
    input  logic [CDBWIDTH-1:0] archtable_copy_20,
    input  logic [CDBWIDTH-1:0] archtable_copy_21,
    input  logic [CDBWIDTH-1:0] archtable_copy_22,
    input  logic [CDBWIDTH-1:0] archtable_copy_23,
    input  logic [CDBWIDTH-1:0] archtable_copy_24,
    input  logic [CDBWIDTH-1:0] archtable_copy_25,
    input  logic [CDBWIDTH-1:0] archtable_copy_26,
    input  logic [CDBWIDTH-1:0] archtable_copy_27,
    input  logic [CDBWIDTH-1:0] archtable_copy_28,
    input  logic [CDBWIDTH-1:0] archtable_copy_29,
    input  logic [CDBWIDTH-1:0] archtable_copy_30,
    input  logic [CDBWIDTH-1:0] archtable_copy_31,
    input  logic                id_destA_en,
    input  logic                id_destB_en,
    input  logic [AREG_W-1:0]   id_destA_idx,
    input  logic [AREG_W-1:0]   id_destB_idx,
    input  logic [CDBWIDTH-1:0] fl_pregA,
    input  logic [CDBWIDTH-1:0] fl_pregB,
    input  logic [AREG_W-1:0]   id_srcA1_idx,
    input  logic [AREG_W-1:0]   id_srcA2_idx,
    input  logic [AREG_W-1:0]   id_srcB1_idx,
    input  logic [AREG_W-1:0]   id_srcB2_idx,
    input  logic                cdbA_en,
    input  logic                cdbB_en,
    input  logic [CDBWIDTH-1:0] cdbA_tag,
    input  logic [CDBWIDTH-1:0] cdbB_tag,
    output logic [CDBWIDTH-1:0] mt_srcA1_preg,
    output logic [CDBWIDTH-1:0] mt_srcA2_preg,
    output logic [CDBWIDTH-1:0] mt_srcB1_preg,
    output logic [CDBWIDTH-1:0] mt_srcB2_preg,
    output logic                mt_srcA1_ready,
    output logic                mt_srcA2_ready,
    output logic                mt_srcB1_ready,
    output logic                mt_srcB2_ready,
    output logic [CDBWIDTH-1:0] mt_oldA_preg,
    output logic [CDBWIDTH-1:0] mt_oldB_preg
);

    entry_t [NUM_AREGS-1:0]                r_table;
    entry_t [NUM_AREGS-1:0]                w_next;
    logic   [NUM_AREGS-1:0][CDBWIDTH-1:0]  w_copy;
    logic                                  w_a_hits_b;

    assign w_copy[0]  = archtable_copy_0;
    assign w_copy[1]  = archtable_copy_1;
    assign w_copy[2]  = archtable_copy_2;
    assign w_copy[3]  = archtable_copy_3;
    assign w_copy[4]  = archtable_copy_4;
    assign w_copy[5]  = archtable_copy_5;
    assign w_copy[6]  = archtable_copy_6;
    assign w_copy[7]  = archtable_copy_7;
    assign w_copy[8]  = archtable_copy_8;
    assign w_copy[9]  = archtable_copy_9;
    assign w_copy[10] = archtable_copy_10;
    assign w_copy[11] = archtable_copy_11;
    assign w_copy[12] = archtable_copy_12;
    assign w_copy[13] = archtable_copy_13;
    assign w_copy[14] = archtable_copy_14;
    assign w_copy[15] = archtable_copy_15;
    assign w_copy[16] = archtable_copy_16;
    assign w_copy[17] = archtable_copy_17;
    assign w_copy[18] = archtable_copy_18;
    assign w_copy[19] = archtable_copy_19;
    assign w_copy[20] = archtable_copy_20;
    assign w_copy[21] = archtable_copy_21;
    assign w_copy[22] = archtable_copy_22;
    assign w_copy[23] = archtable_copy_23;
    assign w_copy[24] = archtable_copy_24;
    assign w_copy[25] = archtable_copy_25;
    assign w_copy[26] = archtable_copy_26;
    assign w_copy[27] = archtable_copy_27;
    assign w_copy[28] = archtable_copy_28;
    assign w_copy[29] = archtable_copy_29;
    assign w_copy[30] = archtable_copy_30;
    assign w_copy[31] = archtable_copy_31;

    // Slot B's old mapping is slot A's new preg when both rename the same register.
    assign w_a_hits_b   = id_destA_en && (id_destA_idx == id_destB_idx) && (id_destA_idx != ZERO_REG);
    assign mt_oldA_preg = r_table[id_destA_idx].preg;
    assign mt_oldB_preg = w_a_hits_b ? fl_pregA : r_table[id_destB_idx].preg;

    always_comb begin
        w_next = r_table;
        for (int i = 0; i < NUM_AREGS; i++) begin
            if ((cdbA_en && (r_table[i].preg == cdbA_tag)) ||
                (cdbB_en && (r_table[i].preg == cdbB_tag))) begin
                w_next[i].ready = 1'b1;
            end
        end
        // Renames come after the CDB so a same-cycle wakeup cannot mark a fresh mapping ready.
        if (id_destA_en && (id_destA_idx != ZERO_REG)) begin
            w_next[id_destA_idx] = '{preg: fl_pregA, ready: 1'b0};
        end
        if (id_destB_en && (id_destB_idx != ZERO_REG)) begin
            w_next[id_destB_idx] = '{preg: fl_pregB, ready: 1'b0};
        end
    end

    // NOTE: every table entry is reset since the identity mapping is architecturally visible.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_AREGS; i++) begin
                // NOTE: sequential state uses non-blocking assignment only.
                r_table[i] <= reset_entry(i);
            end
        end else if (rob_recover) begin
            for (int i = 0; i < NUM_AREGS; i++) begin
                r_table[i] <= '{preg: w_copy[i], ready: 1'b1};
            end
        end else begin
            r_table <= w_next;
        end
    end

    maptable_read_port u_rp_a1 (
        .i_idx      (id_srcA1_idx),
        .i_table    (r_table),
        .i_byp_en   (1'b0),
        .i_byp_idx  (id_destA_idx),
        .i_byp_preg (fl_pregA),
        .i_cdbA_en  (cdbA_en),
        .i_cdbA_tag (cdbA_tag),
        .i_cdbB_en  (cdbB_en),
        .i_cdbB_tag (cdbB_tag),
        .o_preg     (mt_srcA1_preg),
        .o_ready    (mt_srcA1_ready)
    );

    maptable_read_port u_rp_a2 (
        .i_idx      (id_srcA2_idx),
        .i_table    (r_table),
        .i_byp_en   (1'b0),
        .i_byp_idx  (id_destA_idx),
        .i_byp_preg (fl_pregA),
        .i_cdbA_en  (cdbA_en),
        .i_cdbA_tag (cdbA_tag),
        .i_cdbB_en  (cdbB_en),
        .i_cdbB_tag (cdbB_tag),
        .o_preg     (mt_srcA2_preg),
        .o_ready    (mt_srcA2_ready)
    );

    maptable_read_port u_rp_b1 (
        .i_idx      (id_srcB1_idx),
        .i_table    (r_table),
        .i_byp_en   (id_destA_en),
        .i_byp_idx  (id_destA_idx),
        .i_byp_preg (fl_pregA),
        .i_cdbA_en  (cdbA_en),
        .i_cdbA_tag (cdbA_tag),
        .i_cdbB_en  (cdbB_en),
        .i_cdbB_tag (cdbB_tag),
        .o_preg     (mt_srcB1_preg),
        .o_ready    (mt_srcB1_ready)
    );

    maptable_read_port u_rp_b2 (
        .i_idx      (id_srcB2_idx),
        .i_table    (r_table),
        .i_byp_en   (id_destA_en),
        .i_byp_idx  (id_destA_idx),
        .i_byp_preg (fl_pregA),
        .i_cdbA_en  (cdbA_en),
        .i_cdbA_tag (cdbA_tag),
        .i_cdbB_en  (cdbB_en),
        .i_cdbB_tag (cdbB_tag),
        .o_preg     (mt_srcB2_preg),
        .o_ready    (mt_srcB2_ready)
    );

endmodule

// File: tb/tb_maptable.sv
// Directed bench for maptable: expected values are queued as stimulus is
// applied and popped against the DUT outputs at the following falling edge.
module tb_maptable;

    logic       clock;
    logic       reset;
    logic       rob_recover;
    logic [5:0] copy [32];
    logic       id_destA_en, id_destB_en;
    logic [4:0] id_destA_idx, id_destB_idx;
    logic [5:0] fl_pregA, fl_pregB;
    logic [4:0] id_srcA1_idx, id_srcA2_idx, id_srcB1_idx, id_srcB2_idx;
    logic       cdbA_en, cdbB_en;
    logic [5:0] cdbA_tag, cdbB_tag;
    logic [5:0] mt_srcA1_preg, mt_srcA2_preg, mt_srcB1_preg, mt_srcB2_preg;
    logic       mt_srcA1_ready, mt_srcA2_ready, mt_srcB1_ready, mt_srcB2_ready;
    logic [5:0] mt_oldA_preg, mt_oldB_preg;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    sb_t sb [$];
    int  total = 0;
    int  bad   = 0;

    maptable dut (
        .clock             (clock),
        .reset             (reset),
        .rob_recover       (rob_recover),
        .archtable_copy_0  (copy[0]),
        .archtable_copy_1  (copy[1]),
        .archtable_copy_2  (copy[2]),
        .archtable_copy_3  (copy[3]),
        .archtable_copy_4  (copy[4]),
        .archtable_copy_5  (copy[5]),
        .archtable_copy_6  (copy[6]),
        .archtable_copy_7  (copy[7]),
        .archtable_copy_8  (copy[8]),
        .archtable_copy_9  (copy[9]),
        .archtable_copy_10 (copy[10]),
        .archtable_copy_11 (copy[11]),
        .archtable_copy_12 (copy[12]),
        .archtable_copy_13 (copy[13]),
        .archtable_copy_14 (copy[14]),
        .archtable_copy_15 (copy[15]),
        .archtable_copy_16 (copy[16]),
        .archtable_copy_17 (copy[17]),
        .archtable_copy_18 (copy[18]),
        .archtable_copy_19 (copy[19]),
        .archtable_copy_20 (copy[20]),
        .archtable_copy_21 (copy[21]),
        .archtable_copy_22 (copy[22]),
        .archtable_copy_23 (copy[23]),
        .archtable_copy_24 (copy[24]),
        .archtable_copy_25 (copy[25]),
        .archtable_copy_26 (copy[26]),
        .archtable_copy_27 (copy[27]),
        .archtable_copy_28 (copy[28]),
        .archtable_copy_29 (copy[29]),
        .archtable_copy_30 (copy[30]),
        .archtable_copy_31 (copy[31]),
        .id_destA_en       (id_destA_en),
        .id_destB_en       (id_destB_en),
        .id_destA_idx      (id_destA_idx),
        .id_destB_idx      (id_destB_idx),
        .fl_pregA          (fl_pregA),
        .fl_pregB          (fl_pregB),
        .id_srcA1_idx      (id_srcA1_idx),
        .id_srcA2_idx      (id_srcA2_idx),
        .id_srcB1_idx      (id_srcB1_idx),
        .id_srcB2_idx      (id_srcB2_idx),
        .cdbA_en           (cdbA_en),
        .cdbB_en           (cdbB_en),
        .cdbA_tag          (cdbA_tag),
        .cdbB_tag          (cdbB_tag),
        .mt_srcA1_preg     (mt_srcA1_preg),
        .mt_srcA2_preg     (mt_srcA2_preg),
        .mt_srcB1_preg     (mt_srcB1_preg),
        .mt_srcB2_preg     (mt_srcB2_preg),
        .mt_srcA1_ready    (mt_srcA1_ready),
        .mt_srcA2_ready    (mt_srcA2_ready),
        .mt_srcB1_ready    (mt_srcB1_ready),
        .mt_srcB2_ready    (mt_srcB2_ready),
        .mt_oldA_preg      (mt_oldA_preg),
        .mt_oldB_preg      (mt_oldB_preg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic sb_push(input string name, input int exp);
        sb_t e;
        e.name = name;
        e.exp  = 32'(exp);
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        sb_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%0d required=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                bad++;
                $error("FAIL %s observed=%0d required=%0d", e.name, obs, e.exp);
            end
        end
    endtask

    // Advance past the next rising edge; inputs are then driven mid-cycle.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        rob_recover = 1'b0;
        id_destA_en = 1'b0;
        id_destB_en = 1'b0;
        cdbA_en     = 1'b0;
        cdbB_en     = 1'b0;
    endtask

    // Read one entry through srcA1 (no bypass on A sources) at the falling edge.
    task automatic check_entry(input int i, input int exp_preg, input int exp_rdy);
        id_srcA1_idx = 5'(i);
        @(negedge clock);
        sb_push($sformatf("entry%0d_preg", i), exp_preg);
        sb_push($sformatf("entry%0d_ready", i), exp_rdy);
        check(32'(mt_srcA1_preg));
        check(32'(mt_srcA1_ready));
    endtask

    initial begin
        reset        = 1'b1;
        idle();
        id_destA_idx = '0;
        id_destB_idx = '0;
        fl_pregA     = '0;
        fl_pregB     = '0;
        cdbA_tag     = '0;
        cdbB_tag     = '0;
        id_srcA1_idx = '0;
        id_srcA2_idx = '0;
        id_srcB1_idx = '0;
        id_srcB2_idx = '0;
        for (int i = 0; i < 32; i++) copy[i] = 6'(63 - i);
        copy[31] = 6'd31;
        tick();
        tick();
        reset = 1'b0;

        // Identity mapping after reset.
        id_srcA1_idx = 5'd5;  id_srcB1_idx = 5'd31; id_srcB2_idx = 5'd10;
        id_destA_idx = 5'd4;  id_destB_idx = 5'd9;
        @(negedge clock);
        sb_push("rst_a1_preg", 5);   sb_push("rst_a1_ready", 1);
        sb_push("rst_b1_preg", 31);  sb_push("rst_b1_ready", 1);
        sb_push("rst_b2_preg", 10);  sb_push("rst_oldA", 4);  sb_push("rst_oldB", 9);
        check(32'(mt_srcA1_preg));   check(32'(mt_srcA1_ready));
        check(32'(mt_srcB1_preg));   check(32'(mt_srcB1_ready));
        check(32'(mt_srcB2_preg));   check(32'(mt_oldA_preg));    check(32'(mt_oldB_preg));

        // A and B both rename r3; B source sees A's bypass, B's write wins.
        tick();
        id_destA_en = 1'b1; id_destA_idx = 5'd3; fl_pregA = 6'd40;
        id_destB_en = 1'b1; id_destB_idx = 5'd3; fl_pregB = 6'd41;
        id_srcB1_idx = 5'd3; id_srcA1_idx = 5'd3;
        @(negedge clock);
        sb_push("byp_b1_preg", 40);  sb_push("byp_b1_ready", 0);
        sb_push("byp_a1_preg", 3);   sb_push("byp_a1_ready", 1);
        sb_push("byp_oldA", 3);      sb_push("byp_oldB", 40);
        check(32'(mt_srcB1_preg));   check(32'(mt_srcB1_ready));
        check(32'(mt_srcA1_preg));   check(32'(mt_srcA1_ready));
        check(32'(mt_oldA_preg));    check(32'(mt_oldB_preg));
        tick();
        idle();
        check_entry(3, 41, 0);

        // CDB B wakes r3 (preg 41) in the same cycle, then stores it.
        cdbB_en = 1'b1; cdbB_tag = 6'd41; id_srcA2_idx = 5'd3;
        @(negedge clock);
        sb_push("cdbB_byp_ready", 1);
        check(32'(mt_srcA2_ready));
        tick();
        idle();
        check_entry(3, 41, 1);

        // Rename r7 <- 45, then CDB A wakes it.
        tick();
        id_destA_en = 1'b1; id_destA_idx = 5'd7; fl_pregA = 6'd45;
        tick();
        idle();
        check_entry(7, 45, 0);
        cdbA_en = 1'b1; cdbA_tag = 6'd45;
        @(negedge clock);
        sb_push("cdbA_byp_ready", 1);
        check(32'(mt_srcA1_ready));
        tick();
        idle();
        check_entry(7, 45, 1);

        // CDB for old preg 45 coincides with new rename r7 <- 46.
        tick();
        cdbA_en = 1'b1; cdbA_tag = 6'd45;
        id_destA_en = 1'b1; id_destA_idx = 5'd7; fl_pregA = 6'd46;
        id_srcB2_idx = 5'd7;
        @(negedge clock);
        sb_push("conf_b2_preg", 46); sb_push("conf_b2_ready", 0); sb_push("conf_oldA", 45);
        check(32'(mt_srcB2_preg));   check(32'(mt_srcB2_ready));  check(32'(mt_oldA_preg));
        tick();
        idle();
        check_entry(7, 46, 0);

        // Rename of the zero register is suppressed and not bypassed.
        tick();
        id_destA_en = 1'b1; id_destA_idx = 5'd31; fl_pregA = 6'd50;
        id_srcB1_idx = 5'd31;
        @(negedge clock);
        sb_push("zero_b1_preg", 31); sb_push("zero_b1_ready", 1);
        check(32'(mt_srcB1_preg));   check(32'(mt_srcB1_ready));
        tick();
        idle();
        check_entry(31, 31, 1);

        // Recovery with a coincident rename: the rename is discarded.
        tick();
        rob_recover = 1'b1;
        id_destA_en = 1'b1; id_destA_idx = 5'd5; fl_pregA = 6'd60;
        id_destB_en = 1'b1; id_destB_idx = 5'd6; fl_pregB = 6'd61;
        cdbA_en     = 1'b1; cdbA_tag     = 6'd46;
        tick();
        idle();
        for (int i = 0; i < 32; i++) begin
            check_entry(i, (i == 31) ? 31 : 63 - i, 1);
        end

        // Reset together with recovery restores the identity mapping.
        tick();
        id_destA_en = 1'b1; id_destA_idx = 5'd2; fl_pregA = 6'd33;
        tick();
        idle();
        check_entry(2, 33, 0);
        reset = 1'b1; rob_recover = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        for (int i = 0; i < 32; i++) begin
            check_entry(i, i, 1);
        end

        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover observed=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
